// File: rtl/cache_nway_wb_if.sv
// CPU-side and physical-memory-side buses of the write-back cache.
// The slave modport is the cache; the master modport is the CPU plus memory.
interface cache_nway_wb_if #(
  parameter int ADDR_W     = 16,
  parameter int LINE_WORDS = 8
);
  logic [ADDR_W-1:0]        mem_address;
  logic                     mem_read;
  logic                     mem_write;
  logic [1:0]               mem_byte_enable;
  logic [15:0]              mem_wdata;
  logic [15:0]              mem_rdata;
  logic                     mem_resp;
  logic [ADDR_W-1:0]        pmem_address;
  logic                     pmem_read;
  logic                     pmem_write;
  logic [16*LINE_WORDS-1:0] pmem_wdata;
  logic [16*LINE_WORDS-1:0] pmem_rdata;
  logic                     pmem_resp;

  modport master (
    output mem_address, mem_read, mem_write, mem_byte_enable, mem_wdata,
    input  mem_rdata, mem_resp,
    input  pmem_address, pmem_read, pmem_write, pmem_wdata,
    output pmem_rdata, pmem_resp
  );

  modport slave (
    input  mem_address, mem_read, mem_write, mem_byte_enable, mem_wdata,
    output mem_rdata, mem_resp,
    output pmem_address, pmem_read, pmem_write, pmem_wdata,
    input  pmem_rdata, pmem_resp
  );
endinterface

// File: rtl/cache_nway_wb.sv
// N-way set-associative write-back / write-allocate cache with tree PLRU
// replacement, line-granular miss handling and saturating hit/miss counters.
module cache_nway_wb #(
  parameter int WAYS       = 2,
  parameter int SETS       = 8,
  parameter int LINE_WORDS = 8,
  parameter int ADDR_W     = 16,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  cache_nway_wb_if.slave   bus,
  output logic [CNT_W-1:0] hit_count,
  output logic [CNT_W-1:0] miss_count
);
  localparam int WORD_W = $clog2(LINE_WORDS);
  localparam int OFF_W  = WORD_W + 1;
  localparam int IDX_W  = $clog2(SETS);
  localparam int TAG_W  = ADDR_W - OFF_W - IDX_W;
  localparam int WAY_W  = $clog2(WAYS);
  localparam int LINE_W = 16 * LINE_WORDS;

  typedef enum logic [1:0] {IDLE, WRITEBACK, FILL} state_t;
  state_t state_reg, state_next;

  logic              valid_reg [WAYS][SETS];
  logic              dirty_reg [WAYS][SETS];
  logic [TAG_W-1:0]  tag_mem   [WAYS][SETS];
  logic [LINE_W-1:0] data_mem  [WAYS][SETS];
  logic [WAYS-2:0]   plru_reg  [SETS];

  logic [WAY_W-1:0] victim_reg;
  logic [TAG_W-1:0] miss_tag_reg;
  logic [IDX_W-1:0] miss_idx_reg;
  logic             recheck_reg;

  logic [TAG_W-1:0]  req_tag;
  logic [IDX_W-1:0]  req_idx;
  logic [WORD_W-1:0] req_word;
  logic              req;
  logic              unused;
  assign req_tag  = bus.mem_address[ADDR_W-1 -: TAG_W];
  assign req_idx  = bus.mem_address[OFF_W +: IDX_W];
  assign req_word = bus.mem_address[1 +: WORD_W];
  assign req      = bus.mem_read | bus.mem_write;
  assign unused   = bus.mem_address[0];

  logic [WAYS-1:0] hit_vec;
  generate
    for (genvar gi = 0; gi < WAYS; gi++) begin : g_cmp
      assign hit_vec[gi] = valid_reg[gi][req_idx] && (tag_mem[gi][req_idx] == req_tag);
    end
  endgenerate

  logic             hit;
  logic [WAY_W-1:0] hit_way;
  always_comb begin
    hit_way = '0;
    for (int w = WAYS - 1; w >= 0; w--)
      if (hit_vec[w]) hit_way = WAY_W'(w);
  end
  assign hit = |hit_vec;

  // Tree nodes use heap numbering (root = 1, node n stored at bit n-1);
  // a node bit of 1 means the victim lies in the upper-index subtree.
  logic [WAY_W-1:0] victim_way;
  logic [WAYS-2:0]  plru_upd;
  always_comb begin
    int  node;
    logic found;
    node = 1;
    for (int l = 0; l < WAY_W; l++)
      node = 2 * node + int'(plru_reg[req_idx][node-1]);
    victim_way = WAY_W'(node - WAYS);
    found = 1'b0;
    for (int w = 0; w < WAYS; w++)
      if (!found && !valid_reg[w][req_idx]) begin
        victim_way = WAY_W'(w);
        found      = 1'b1;
      end
  end

  always_comb begin
    int path;
    int node;
    plru_upd = plru_reg[req_idx];
    path     = int'(hit_way) + WAYS;
    for (int l = 0; l < WAY_W; l++) begin
      node               = path >> (WAY_W - l);
      plru_upd[node-1]   = ~path[WAY_W-l-1];
    end
  end

  logic              resp, pm_read, pm_write, do_hit, do_miss, fill_done;
  logic [ADDR_W-1:0] pm_address;
  always_comb begin
    state_next = state_reg;
    resp       = 1'b0;
    pm_read    = 1'b0;
    pm_write   = 1'b0;
    pm_address = '0;
    do_hit     = 1'b0;
    do_miss    = 1'b0;
    fill_done  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (req) begin
          if (hit) begin
            resp   = 1'b1;
            do_hit = 1'b1;
          end else begin
            do_miss    = 1'b1;
            state_next = dirty_reg[victim_way][req_idx] ? WRITEBACK : FILL;
          end
        end
      end
      WRITEBACK: begin
        pm_write   = 1'b1;
        pm_address = {tag_mem[victim_reg][miss_idx_reg], miss_idx_reg, {OFF_W{1'b0}}};
        if (bus.pmem_resp) state_next = FILL;
      end
      FILL: begin
        pm_read    = 1'b1;
        pm_address = {miss_tag_reg, miss_idx_reg, {OFF_W{1'b0}}};
        if (bus.pmem_resp) begin
          fill_done  = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  logic [LINE_W-1:0] hit_line;
  assign hit_line         = data_mem[hit_way][req_idx];
  assign bus.mem_rdata    = hit_line[{req_word, 4'b0000} +: 16];
  assign bus.mem_resp     = resp;
  assign bus.pmem_read    = pm_read;
  assign bus.pmem_write   = pm_write;
  assign bus.pmem_address = pm_address;
  assign bus.pmem_wdata   = data_mem[victim_reg][miss_idx_reg];

  always_ff @(posedge clk) begin
    if (!reset_n) state_reg <= IDLE;
    else          state_reg <= state_next;
  end

  // The hit that follows a fill completes a miss, so it is not a new hit.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int w = 0; w < WAYS; w++)
        for (int s = 0; s < SETS; s++) begin
          valid_reg[w][s] <= 1'b0;
          dirty_reg[w][s] <= 1'b0;
        end
      for (int s = 0; s < SETS; s++) plru_reg[s] <= '0;
      hit_count   <= '0;
      miss_count  <= '0;
      recheck_reg <= 1'b0;
    end else begin
      recheck_reg <= fill_done;
      if (fill_done) begin
        valid_reg[victim_reg][miss_idx_reg] <= 1'b1;
        dirty_reg[victim_reg][miss_idx_reg] <= 1'b0;
      end
      if (do_hit) begin
        plru_reg[req_idx] <= plru_upd;
        if (bus.mem_write) dirty_reg[hit_way][req_idx] <= 1'b1;
        if (!recheck_reg && hit_count != {CNT_W{1'b1}}) hit_count <= hit_count + 1'b1;
      end
      if (do_miss && miss_count != {CNT_W{1'b1}}) miss_count <= miss_count + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_miss) begin
      victim_reg   <= victim_way;
      miss_tag_reg <= req_tag;
      miss_idx_reg <= req_idx;
    end
    if (fill_done) begin
      data_mem[victim_reg][miss_idx_reg] <= bus.pmem_rdata;
      tag_mem[victim_reg][miss_idx_reg]  <= miss_tag_reg;
    end else if (do_hit && bus.mem_write) begin
      if (bus.mem_byte_enable[0])
        data_mem[hit_way][req_idx][{req_word, 4'b0000} +: 8] <= bus.mem_wdata[7:0];
      if (bus.mem_byte_enable[1])
        data_mem[hit_way][req_idx][{req_word, 4'b1000} +: 8] <= bus.mem_wdata[15:8];
    end
  end
endmodule

// File: doc/cache_nway_wb.md
Name: cache_nway_wb

Overview:
Parametrised N-way set-associative, write-back, write-allocate cache for the LC-3b memory hierarchy. Integrates tag/valid/dirty/data storage, a tree pseudo-LRU replacement policy and the miss-handling controller in a single block. Sits between the CPU memory port (16-bit word, byte-enabled, held-until-resp handshake) and physical memory (one full line per transfer). Adds saturating hit/miss performance counters.

Parameters:
WAYS, 2, associativity; power of 2, range 2..8
SETS, 8, number of sets; power of 2, minimum 2
LINE_WORDS, 8, 16-bit words per line; power of 2, minimum 2
ADDR_W, 16, byte address width
CNT_W, 16, width of each performance counter

Ports:
clk  in  1  clock; all state updates on the rising edge
reset_n  in  1  synchronous active-low reset
mem_address  in  ADDR_W  CPU byte address
mem_read  in  1  CPU read request; held until mem_resp
mem_write  in  1  CPU write request; held until mem_resp
mem_byte_enable  in  2  byte lanes for a write
mem_wdata  in  16  CPU write word
mem_rdata  out  16  CPU read word
mem_resp  out  1  one-cycle completion pulse
pmem_address  out  ADDR_W  line-aligned physical address
pmem_read  out  1  line fill request
pmem_write  out  1  line writeback request
pmem_wdata  out  16*LINE_WORDS  victim line
pmem_rdata  in  16*LINE_WORDS  fill line
pmem_resp  in  1  physical transfer complete
hit_count  out  CNT_W  saturating count of hit responses
miss_count  out  CNT_W  saturating count of misses

Behaviour:
- Address split: offset = log2(LINE_WORDS)+1 LSBs (byte), index = next log2(SETS) bits, tag = remainder. Defaults give 4/3/9.
- Storage: per way, valid/dirty/tag/data arrays; per set, WAYS-1 PLRU tree bits. Reads are asynchronous and writes synchronous.
- Reset (reset_n low at an edge):
  - Clears all valid, dirty and PLRU bits, both counters and the state (to IDLE).
  - Data and tag contents are unspecified.
  - Outputs after reset: mem_resp, pmem_read and pmem_write are 0; pmem_address is 0.
- FSM, IDLE:
  - With no request, stays in IDLE.
  - With a request, a tag match on a valid way is a hit: mem_resp=1 in the same cycle (0 extra cycles) and hit_count increments.
  - Read hit: mem_rdata = the selected word.
  - Write hit: merge mem_wdata into the word per byte_enable (bit0 -> [7:0], bit1 -> [15:8]); set dirty.
  - Any hit updates the PLRU bits to point away from the accessed way.
- FSM, miss handling:
  - A miss increments miss_count once and latches the victim way.
  - Victim selection: the lowest-index invalid way; otherwise the PLRU victim.
  - Victim dirty -> WRITEBACK; otherwise -> FILL.
- WRITEBACK:
  - pmem_write=1, pmem_address={victim tag, index, 0}, pmem_wdata = victim line.
  - On pmem_resp, go to FILL.
- FILL:
  - pmem_read=1, pmem_address={req tag, index, 0}.
  - On pmem_resp, write the line, tag, valid=1 and dirty=0, then return to IDLE.
  - IDLE then re-checks the request and hits. That access counts as a miss only; hit_count does not increment on the re-check.
- Both mem_read and mem_write asserted: treated as a write.
- Request dropped mid-miss: illegal; the fill still completes.
- pmem_resp outside WRITEBACK/FILL: ignored.
- Counters saturate at 2^CNT_W-1 and do not wrap.
- Reset mid-WRITEBACK or mid-FILL: aborts immediately. Next cycle pmem_read/pmem_write are 0, and the line being filled is left invalid.

Test Plan:
- Config WAYS=4. Reset, then read 0x1234: pmem_read=1 with pmem_address=0x1230 and no writeback. Return line with word2=0xBEEF: mem_rdata=0xBEEF with one mem_resp; miss_count=1, hit_count=0. Repeat the read: mem_resp in the request cycle, hit_count=1.
- Read 0x1236 (word 3 = 0x5555) to load the line. Write 0x1236, byte_enable=01, wdata=0xABCD: hit, no pmem activity. Read back 0x1236: 0x55CD. Line dirty.
- Set 3, WAYS=4: miss-fill tags A,B,C,D (no writeback; invalid ways used 0,1,2,3). Access A, C. Miss on tag E: victim = PLRU way (way 1, tag B), clean so FILL only. Repeat with B dirty: pmem_write first, address {B,3,0}, old line data, then pmem_read.
- Assert reset_n=0 for one cycle during FILL, before pmem_resp: next cycle pmem_read=0, mem_resp=0, counters 0. Same read afterwards misses again.
- CNT_W=4: 20 consecutive hits -> hit_count=15 (saturated). miss_count unchanged.
- WAYS=2, SETS=2: alternate three tags mapping to set 0. Each access misses and evicts the LRU way, and dirty victims write back with correct addresses.
